// File: rtl/iir_sched_pkg.sv
// -----------------------------------------------------------------------------
// iir_sched_pkg
// Shared types and constants for the stereo first-order IIR scheduler.
//   state_t       : scheduler FSM states
//   DEF_*         : default quantized coefficients and fraction width
//   dequantize()  : signed divide by 2**qbits, truncating toward zero
// -----------------------------------------------------------------------------
package iir_sched_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MAC0  = 3'd1,
        MAC1  = 3'd2,
        MAC2  = 3'd3,
        WRITE = 3'd4
    } state_t;

    localparam int unsigned DEF_QUANT_BITS = 32'd10;
    localparam int          DEF_B0         = 178;
    localparam int          DEF_B1         = 178;
    localparam int          DEF_A1         = -666;

    // A plain arithmetic shift rounds toward minus infinity; biasing negative
    // values by (2**qbits - 1) first makes the shift truncate toward zero,
    // matching a signed integer divide.
    function automatic logic signed [127:0] dequantize(
        input logic signed [127:0] prod,
        input int unsigned         qbits
    );
        logic signed [127:0] bias;
        if (prod < 128'sd0) begin
            bias = (128'sd1 <<< qbits) - 128'sd1;
        end else begin
            bias = 128'sd0;
        end
        return (prod + bias) >>> qbits;
    endfunction

endpackage

// File: rtl/iir_stereo_sched_mac.sv
// -----------------------------------------------------------------------------
// iir_mac_unit
// Single shared multiplier with dequantize and accumulate.
//   clk, rst      : clock, asynchronous active-high reset
//   i_en          : update the accumulator this cycle
//   i_clear_acc   : start a new sum (ignore i_acc_in)
//   i_operand     : sample / history operand
//   i_coef        : quantized coefficient
//   i_acc_in      : running sum to add to
//   o_acc_out     : registered (clear ? 0 : acc_in) + DQ(operand*coef)
// -----------------------------------------------------------------------------
module iir_mac_unit
    import iir_sched_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned QUANT_BITS = DEF_QUANT_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_en,
    input  logic                         i_clear_acc,
    input  logic signed [DATA_WIDTH-1:0] i_operand,
    input  logic signed [DATA_WIDTH-1:0] i_coef,
    input  logic signed [DATA_WIDTH-1:0] i_acc_in,
    output logic signed [DATA_WIDTH-1:0] o_acc_out
);

    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [DATA_WIDTH-1:0]   w_term;
    logic signed [DATA_WIDTH-1:0]   w_base;
    logic signed [DATA_WIDTH-1:0]   w_sum;
    logic signed [DATA_WIDTH-1:0]   r_acc;

    assign w_prod = i_operand * i_coef;
    // Dequantized term is truncated back to the sample width; sums wrap.
    assign w_term = DATA_WIDTH'(dequantize(128'(w_prod), QUANT_BITS));
    assign w_base = i_clear_acc ? {DATA_WIDTH{1'b0}} : i_acc_in;
    assign w_sum  = w_base + w_term;

    // Accumulator register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= {DATA_WIDTH{1'b0}};
        end else if (i_en) begin
            r_acc <= w_sum;
        end else begin
            r_acc <= r_acc;
        end
    end

    assign o_acc_out = r_acc;

endmodule

// File: rtl/iir_stereo_sched.sv
// -----------------------------------------------------------------------------
// iir_stereo_sched
// Round-robin scheduler sharing one IIR MAC between L (0) and R (1) channels.
//   y[n] = DQ(B0*x[n]) + DQ(B1*x[n-1]) + DQ(A1*y[n-1])
//   clock, reset : clock, asynchronous active-high reset
//   din          : per-channel FWFT sample (index 0 = L, 1 = R)
//   in_empty     : per-channel upstream empty
//   in_rd_en     : per-channel pop strobe (combinational, in the grant cycle)
//   dout         : filtered sample, valid while an out_wr_en bit is high
//   out_full     : per-channel downstream full
//   out_wr_en    : per-channel push strobe, at most one high
//   busy         : FSM not in IDLE
// -----------------------------------------------------------------------------
module iir_stereo_sched
    import iir_sched_pkg::*;
#(
    parameter int          DATA_WIDTH = 32,
    parameter int unsigned QUANT_BITS = DEF_QUANT_BITS,
    parameter int          B0         = DEF_B0,
    parameter int          B1         = DEF_B1,
    parameter int          A1         = DEF_A1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [1:0][DATA_WIDTH-1:0] din,
    input  logic [1:0]                 in_empty,
    output logic [1:0]                 in_rd_en,
    output logic [DATA_WIDTH-1:0]      dout,
    input  logic [1:0]                 out_full,
    output logic [1:0]                 out_wr_en,
    output logic                       busy
);

    localparam logic signed [DATA_WIDTH-1:0] C_B0 = DATA_WIDTH'(B0);
    localparam logic signed [DATA_WIDTH-1:0] C_B1 = DATA_WIDTH'(B1);
    localparam logic signed [DATA_WIDTH-1:0] C_A1 = DATA_WIDTH'(A1);

    state_t                       r_state;
    state_t                       w_state_next;
    logic                         r_rr_ptr;
    logic                         r_ch_reg;
    logic signed [DATA_WIDTH-1:0] r_x_reg;
    logic signed [DATA_WIDTH-1:0] r_x1 [2];
    logic signed [DATA_WIDTH-1:0] r_y1 [2];

    logic [1:0]                   w_elig;
    logic                         w_grant_vld;
    logic                         w_grant_ch;
    logic [1:0]                   w_rd_en;
    logic [1:0]                   w_wr_en;
    logic                         w_wr_any;
    logic                         w_mac_en;
    logic                         w_mac_clear;
    logic signed [DATA_WIDTH-1:0] w_operand;
    logic signed [DATA_WIDTH-1:0] w_coef;
    logic signed [DATA_WIDTH-1:0] w_acc;

    assign w_elig   = ~in_empty & ~out_full;
    assign w_wr_any = |w_wr_en;

    // FSM state register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state, round-robin grant and FIFO strobes.
    always_comb begin
        w_state_next = r_state;
        w_grant_vld  = 1'b0;
        w_grant_ch   = 1'b0;
        w_rd_en      = 2'b00;
        w_wr_en      = 2'b00;
        case (r_state)
            IDLE: begin
                if (w_elig[r_rr_ptr]) begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = r_rr_ptr;
                end else if (w_elig[~r_rr_ptr]) begin
                    w_grant_vld = 1'b1;
                    w_grant_ch  = ~r_rr_ptr;
                end else begin
                    w_grant_vld = 1'b0;
                end
                if (w_grant_vld) begin
                    w_rd_en[w_grant_ch] = 1'b1;
                    w_state_next        = MAC0;
                end else begin
                    w_state_next = IDLE;
                end
            end
            MAC0:    w_state_next = MAC1;
            MAC1:    w_state_next = MAC2;
            MAC2:    w_state_next = WRITE;
            WRITE: begin
                // A full downstream FIFO parks the finished sample here.
                if (!out_full[r_ch_reg]) begin
                    w_wr_en[r_ch_reg] = 1'b1;
                    w_state_next      = IDLE;
                end else begin
                    w_state_next = WRITE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Operand/coefficient select for the shared multiplier.
    always_comb begin
        w_operand   = {DATA_WIDTH{1'b0}};
        w_coef      = {DATA_WIDTH{1'b0}};
        w_mac_en    = 1'b0;
        w_mac_clear = 1'b0;
        case (r_state)
            MAC0: begin
                w_operand   = r_x_reg;
                w_coef      = C_B0;
                w_mac_en    = 1'b1;
                w_mac_clear = 1'b1;
            end
            MAC1: begin
                w_operand = r_x1[r_ch_reg];
                w_coef    = C_B1;
                w_mac_en  = 1'b1;
            end
            MAC2: begin
                w_operand = r_y1[r_ch_reg];
                w_coef    = C_A1;
                w_mac_en  = 1'b1;
            end
            default: begin
                w_mac_en = 1'b0;
            end
        endcase
    end

    // Grant capture, per-channel history and round-robin pointer.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_x_reg  <= {DATA_WIDTH{1'b0}};
            r_ch_reg <= 1'b0;
            r_rr_ptr <= 1'b0;
            for (int c = 0; c < 2; c++) begin
                r_x1[c] <= {DATA_WIDTH{1'b0}};
                r_y1[c] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            if (w_grant_vld) begin
                r_x_reg  <= din[w_grant_ch];
                r_ch_reg <= w_grant_ch;
            end
            // History only advances when the sample actually leaves.
            if (w_wr_any) begin
                r_x1[r_ch_reg] <= r_x_reg;
                r_y1[r_ch_reg] <= w_acc;
                r_rr_ptr       <= ~r_ch_reg;
            end
        end
    end

    iir_mac_unit #(
        .DATA_WIDTH (DATA_WIDTH),
        .QUANT_BITS (QUANT_BITS)
    ) u_mac (
        .clk         (clock),
        .rst         (reset),
        .i_en        (w_mac_en),
        .i_clear_acc (w_mac_clear),
        .i_operand   (w_operand),
        .i_coef      (w_coef),
        .i_acc_in    (w_acc),
        .o_acc_out   (w_acc)
    );

    assign in_rd_en  = w_rd_en;
    assign out_wr_en = w_wr_en;
    assign dout      = w_wr_any ? w_acc : {DATA_WIDTH{1'b0}};
    assign busy      = (r_state != IDLE);

endmodule
